// File: rtl/compressor_feed_ctrl.sv
// Column-beat feeder for a serial compressor harness: shifts DEPTH column beats
// into the lanes, waits out the compressor latency, then holds the result until taken.
module compressor_feed_ctrl #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned OUT_W = 37,
  parameter int unsigned LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_col,
  output logic             shift_en,
  output logic [LANES-1:0] shift_bits,
  input  logic [OUT_W-1:0] dst,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             busy,
  output logic [15:0]      done_cnt
);

  localparam int unsigned BCNT_W = 6;
  localparam int unsigned WCNT_W = 4;
  localparam int unsigned DONE_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

  state_t              state, state_next;
  logic [BCNT_W-1:0]   beat_cnt, beat_cnt_next;
  logic [WCNT_W-1:0]   wait_cnt, wait_cnt_next;
  logic                res_valid_next;
  logic [OUT_W-1:0]    res_data_next;
  logic [DONE_W-1:0]   done_cnt_next;
  logic                busy_next;

  // Beat acceptance is combinational so the harness shifts on the accepting edge;
  // gating with rst_n keeps the input closed while reset is held.
  assign in_ready   = rst_n & ((state == IDLE) | (state == LOAD));
  assign shift_en   = in_valid & in_ready;
  assign shift_bits = shift_en ? in_col : LANES'(0);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      done_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_cnt_next;
      wait_cnt  <= wait_cnt_next;
      res_valid <= res_valid_next;
      res_data  <= res_data_next;
      done_cnt  <= done_cnt_next;
      busy      <= busy_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next     = state;
    beat_cnt_next  = beat_cnt;
    wait_cnt_next  = wait_cnt;
    res_valid_next = res_valid;
    res_data_next  = res_data;
    done_cnt_next  = done_cnt;

    unique case (state)
      IDLE: begin
        if (shift_en) begin
          if (DEPTH == 1) begin
            state_next = WAIT;
          end else begin
            state_next    = LOAD;
            beat_cnt_next = BCNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (shift_en) begin
          if (beat_cnt == BCNT_W'(DEPTH - 1)) begin
            state_next    = WAIT;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt + BCNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (wait_cnt == WCNT_W'(LAT)) begin
          state_next     = HOLD;
          wait_cnt_next  = '0;
          res_data_next  = dst;
          res_valid_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + WCNT_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_next     = IDLE;
          res_valid_next = 1'b0;
          done_cnt_next  = done_cnt + DONE_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
